// File: rtl/pe.sv
// ----------------------------------------------------------------------------
// pe -- mesh processing element executing a small ROM program on one record.
//
// Each clock the PE runs the 4-bit instruction at ROM[pc]. The instruction can
// copy a neighbour's record, take a max/min against one, reload the reset
// value, halt, or loop back to pc 0. Execution stops once the instruction
// budget (SORT_CYCLES*COMPUTE_CYCLES) is spent or a HALT runs.
//
// The program image is passed in through PROGRAM, one word per nibble, with
// ROM[k] = PROGRAM[4k +: 4]. FILENAME is kept so the parameter list stays
// unchanged and still names the image source.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   rst_memory : address field loaded into the record on reset
//   i_PE_l/r/u/d : neighbour records (left/right/up/down)
//   o_PE       : current record, driven straight from the register
// ----------------------------------------------------------------------------
module pe #(
    parameter int N              = 1,
    parameter int SQRT_N         = 0,
    parameter int I              = 0,
    parameter     FILENAME       = "program.data",
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 3,
    parameter int SORT_CYCLES    = 1,
    parameter int COMPUTE_CYCLES = 1,
    parameter int FIRST_IN_ROW   = 0,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1,
    parameter logic [4*(2**ADDR_WIDTH)-1:0]     PROGRAM = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              rst_memory,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_l,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_r,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_u,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE_d,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0]   o_PE
);

    localparam int          W      = ADDR_WIDTH + DATA_WIDTH;
    localparam int          DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned BUDGET = SORT_CYCLES * COMPUTE_CYCLES;
    localparam int unsigned CW     = (BUDGET == 0) ? 1 : $clog2(BUDGET + 1);
    localparam logic [CW-1:0]         LP_BUDGET  = CW'(BUDGET);
    localparam logic [DATA_WIDTH-1:0] LP_I_FIELD = DATA_WIDTH'(I);

    // Descriptive parameters only; an empty block marks an unusable set.
    localparam bit LP_CFG_OK = (N >= 1) && (SQRT_N >= 0) &&
                               ($bits(FILENAME) > 0) && (MAX_INT != '0);
    if (!LP_CFG_OK) begin : g_cfg_invalid
    end

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_S_L   = 4'd1,
        OP_S_R   = 4'd2,
        OP_S_U   = 4'd3,
        OP_S_D   = 4'd4,
        OP_MAX_L = 4'd5,
        OP_MIN_R = 4'd6,
        OP_MAX_U = 4'd7,
        OP_MIN_D = 4'd8,
        OP_RLD   = 4'd9,
        OP_HALT  = 4'd10,
        OP_LOOP  = 4'd11
    } opcode_t;

    logic [W-1:0]          r_rec;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [CW-1:0]         r_cnt;
    logic                  r_done;

    logic [3:0]            w_rom [DEPTH];
    opcode_t               w_op;
    logic [W-1:0]          w_reset_val;
    logic [W-1:0]          w_rec_next;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  w_halt;
    logic                  w_exec;

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_rom[k] = PROGRAM[4*k +: 4];
        end
    end

    assign w_op        = opcode_t'(w_rom[r_pc]);
    assign w_reset_val = {rst_memory, LP_I_FIELD};
    // A zero budget never executes; otherwise run until the count is spent.
    assign w_exec      = !r_done && (r_cnt != LP_BUDGET);

    always_comb begin
        w_rec_next = r_rec;
        w_pc_next  = r_pc + 1'b1;
        w_halt     = 1'b0;
        case (w_op)
            OP_S_L:   if (FIRST_IN_ROW == 0) w_rec_next = i_PE_l;
            OP_S_R:   w_rec_next = i_PE_r;
            OP_S_U:   w_rec_next = i_PE_u;
            OP_S_D:   w_rec_next = i_PE_d;
            OP_MAX_L: if (FIRST_IN_ROW == 0 && i_PE_l > r_rec) w_rec_next = i_PE_l;
            OP_MIN_R: if (i_PE_r < r_rec) w_rec_next = i_PE_r;
            OP_MAX_U: if (i_PE_u > r_rec) w_rec_next = i_PE_u;
            OP_MIN_D: if (i_PE_d < r_rec) w_rec_next = i_PE_d;
            OP_RLD:   w_rec_next = w_reset_val;
            OP_HALT:  w_halt = 1'b1;
            OP_LOOP:  w_pc_next = '0;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rec  <= w_reset_val;
            r_pc   <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (w_exec) begin
            r_rec <= w_rec_next;
            r_pc  <= w_pc_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_halt || (r_cnt + 1'b1) == LP_BUDGET) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_PE = r_rec;

endmodule

// File: tb/tb_pe.sv
// ----------------------------------------------------------------------------
// tb_pe -- bench for pe. Eight PE instances with different programs share one
// clock, reset and neighbour bus. A behavioural model in the bench predicts
// every record; directed literal checks pin the model at key points.
// ----------------------------------------------------------------------------
module tb_pe;

    localparam int NI = 8;

    logic       clk;
    logic       rst;
    logic [5:0] in_l, in_r, in_u, in_d;
    logic [5:0] dut_out [NI];

    int n_checks = 0;
    int n_pass   = 0;

    // Programs written as plain opcode lists (ROM[0] first).
    localparam int P_PROG [NI][8] = '{
        '{1, 0, 0, 0, 0, 0, 0, 0},     // 0: S_L
        '{4, 0, 0, 0, 0, 0, 0, 0},     // 1: S_D
        '{2, 0, 0, 0, 0, 0, 0, 0},     // 2: S_R
        '{1, 0, 0, 0, 0, 0, 0, 0},     // 3: S_L on left edge
        '{3, 6, 5, 4, 9, 0, 0, 0},     // 4: sort sequence, RLD must never run
        '{7, 8, 0, 9, 12, 5, 11, 10},  // 5: mixed ops with LOOP
        '{1, 10, 2, 0, 0, 0, 0, 0},    // 6: HALT
        '{1, 0, 0, 0, 0, 0, 0, 2}      // 7: pc wrap
    };
    localparam int P_BUDGET [NI] = '{1, 1, 1, 1, 4, 16, 8, 9};
    localparam int P_FIRST  [NI] = '{0, 0, 0, 1, 0, 0, 0, 0};
    // {rst_memory, I[2:0]}
    localparam int P_RSTVAL [NI] = '{42, 42, 42, 0, 53, 19, 63, 9};

    pe #(.I(2), .PROGRAM(32'h0000_0001)) u_pe0 (
        .clk(clk), .rst(rst), .rst_memory(3'd5),
        .i_PE_l(in_l), .i_PE_r(in_r), .i_PE_u(in_u), .i_PE_d(in_d), .o_PE(dut_out[0]));
    pe #(.I(2), .PROGRAM(32'h0000_0004)) u_pe1 (
        .clk(clk), .rst(rst), .rst_memory(3'd5),
        .i_PE_l(in_l), .i_PE_r(in_r), .i_PE_u(in_u), .i_PE_d(in_d), .o_PE(dut_out[1]));
    pe #(.I(2), .PROGRAM(32'h0000_0002)) u_pe2 (
        .clk(clk), .rst(rst), .rst_memory(3'd5),
        .i_PE_l(in_l), .i_PE_r(in_r), .i_PE_u(in_u), .i_PE_d(in_d), .o_PE(dut_out[2]));
    pe #(.I(0), .FIRST_IN_ROW(1), .PROGRAM(32'h0000_0001)) u_pe3 (
        .clk(clk), .rst(rst), .rst_memory(3'd0),
        .i_PE_l(in_l), .i_PE_r(in_r), .i_PE_u(in_u), .i_PE_d(in_d), .o_PE(dut_out[3]));
    pe #(.I(5), .SORT_CYCLES(2), .COMPUTE_CYCLES(2), .PROGRAM(32'h0009_4563)) u_pe4 (
        .clk(clk), .rst(rst), .rst_memory(3'd6),
        .i_PE_l(in_l), .i_PE_r(in_r), .i_PE_u(in_u), .i_PE_d(in_d), .o_PE(dut_out[4]));
    pe #(.I(3), .SORT_CYCLES(4), .COMPUTE_CYCLES(4), .PROGRAM(32'hAB5C_9087)) u_pe5 (
        .clk(clk), .rst(rst), .rst_memory(3'd2),
        .i_PE_l(in_l), .i_PE_r(in_r), .i_PE_u(in_u), .i_PE_d(in_d), .o_PE(dut_out[5]));
    pe #(.I(7), .SORT_CYCLES(2), .COMPUTE_CYCLES(4), .PROGRAM(32'h0000_02A1)) u_pe6 (
        .clk(clk), .rst(rst), .rst_memory(3'd7),
        .i_PE_l(in_l), .i_PE_r(in_r), .i_PE_u(in_u), .i_PE_d(in_d), .o_PE(dut_out[6]));
    pe #(.I(1), .SORT_CYCLES(3), .COMPUTE_CYCLES(3), .PROGRAM(32'h2000_0001)) u_pe7 (
        .clk(clk), .rst(rst), .rst_memory(3'd1),
        .i_PE_l(in_l), .i_PE_r(in_r), .i_PE_u(in_u), .i_PE_d(in_d), .o_PE(dut_out[7]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int m_rec  [NI];
    int m_pc   [NI];
    int m_used [NI];
    bit m_halt [NI];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                m_rec[k]  <= P_RSTVAL[k];
                m_pc[k]   <= 0;
                m_used[k] <= 0;
                m_halt[k] <= 1'b0;
            end
            m_valid <= 1'b1;
        end else if (m_valid) begin
            for (int k = 0; k < NI; k++) begin
                if (!m_halt[k] && m_used[k] < P_BUDGET[k]) begin
                    automatic int op  = P_PROG[k][m_pc[k]];
                    automatic int v   = m_rec[k];
                    automatic int npc = (m_pc[k] + 1) % 8;
                    automatic int l   = int'(in_l);
                    automatic int r   = int'(in_r);
                    automatic int u   = int'(in_u);
                    automatic int d   = int'(in_d);
                    case (op)
                        1:  if (P_FIRST[k] == 0) v = l;
                        2:  v = r;
                        3:  v = u;
                        4:  v = d;
                        5:  if (P_FIRST[k] == 0 && l > v) v = l;
                        6:  if (r < v) v = r;
                        7:  if (u > v) v = u;
                        8:  if (d < v) v = d;
                        9:  v = P_RSTVAL[k];
                        10: m_halt[k] <= 1'b1;
                        11: npc = 0;
                        default: ;
                    endcase
                    m_rec[k]  <= v;
                    m_pc[k]   <= npc;
                    m_used[k] <= m_used[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("model_pe%0d", k), int'(dut_out[k]), m_rec[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input int l, input int r, input int u, input int d);
        in_l = 6'(l);
        in_r = 6'(r);
        in_u = 6'(u);
        in_d = 6'(d);
    endtask

    initial begin
        rst = 1'b1;
        set_in(1, 2, 3, 4);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_val_pe0", int'(dut_out[0]), 42);   // 101_010
        check("rst_val_pe3", int'(dut_out[3]), 0);
        check("rst_val_pe4", int'(dut_out[4]), 53);   // 110_101
        @(negedge clk);
        check("rst_held_pe0", int'(dut_out[0]), 42);
        rst = 1'b0;

        @(negedge clk);                               // edge 1
        check("s_l_first", int'(dut_out[0]), 1);
        check("s_d_first", int'(dut_out[1]), 4);
        check("s_r_first", int'(dut_out[2]), 2);
        check("edge_s_l",  int'(dut_out[3]), 0);
        check("seq_e1",    int'(dut_out[4]), 3);
        check("halt_s_l",  int'(dut_out[6]), 1);
        @(negedge clk);
        check("seq_e2",    int'(dut_out[4]), 2);
        @(negedge clk);
        check("seq_e3",    int'(dut_out[4]), 2);
        @(negedge clk);
        check("seq_e4",    int'(dut_out[4]), 4);
        @(negedge clk);                               // edge 5
        check("s_l_hold",  int'(dut_out[0]), 1);
        check("s_d_hold",  int'(dut_out[1]), 4);
        check("s_r_hold",  int'(dut_out[2]), 2);
        check("seq_hold",  int'(dut_out[4]), 4);
        check("edge_hold", int'(dut_out[3]), 0);

        // Varying neighbours: budgeted/halted PEs must ignore them.
        for (int k = 0; k < 20; k++) begin
            set_in((k * 7 + 5) % 64, (k * 13 + 40) % 64,
                   (k * 29 + 11) % 64, (k * 17 + 60) % 64);
            @(negedge clk);
        end
        check("seq_final",  int'(dut_out[4]), 4);
        check("halt_final", int'(dut_out[6]), 1);
        check("s_l_final",  int'(dut_out[0]), 1);

        // Mid-program reset of the sort sequence.
        set_in(1, 2, 3, 4);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_pe4", int'(dut_out[4]), 53);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_e1", int'(dut_out[4]), 3);
        @(negedge clk);
        check("rst2_e2", int'(dut_out[4]), 2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rst", int'(dut_out[4]), 53);
        rst = 1'b0;
        @(negedge clk);
        check("restart_e1", int'(dut_out[4]), 3);
        for (int k = 0; k < 6; k++) @(negedge clk);
        check("restart_final", int'(dut_out[4]), 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe.md
PE -- requirements
Module: pe

Interface
REQ-001 Parameter N, default 1: number of PEs in the mesh; informational, SHALL be >= 1.
REQ-002 Parameter SQRT_N, default 0: mesh side length; informational, no functional effect.
REQ-003 Parameter I, default 0: PE index; its low DATA_WIDTH bits form the reset data field.
REQ-004 Parameter FILENAME, default "program.data": program image, binary text, one 4-bit word per line, loaded at elaboration.
REQ-005 Parameter ADDR_WIDTH, default 3: record address-field width; program ROM depth = 2^ADDR_WIDTH words.
REQ-006 Parameter DATA_WIDTH, default 3: record data-field width; W = ADDR_WIDTH+DATA_WIDTH.
REQ-007 Parameter SORT_CYCLES, default 1: sort phases.
REQ-008 Parameter COMPUTE_CYCLES, default 1: instructions per sort phase.
REQ-009 Parameter FIRST_IN_ROW, default 0: 1 = PE sits on the left mesh edge.
REQ-010 Parameter MAX_INT, default all-ones (W bits): largest record value.
REQ-011 clk  input  1  single clock, all state updates on rising edge.
REQ-012 rst  input  1  reset, synchronous and active-high.
REQ-013 rst_memory  input  ADDR_WIDTH  address field loaded into the record on reset.
REQ-014 i_PE_l / i_PE_r / i_PE_u / i_PE_d  input  W each  records from the left/right/up/down neighbours.
REQ-015 o_PE  output  W  current record register r, driven directly from the register.

Function
REQ-016 State: record r (W bits), program counter pc (ADDR_WIDTH bits), budget counter, done flag.
REQ-017 Budget = SORT_CYCLES*COMPUTE_CYCLES instructions; after that many executions done SHALL be set and r, pc SHALL hold.
REQ-018 Each non-reset edge with done=0: execute ROM[pc], update r at that same edge, pc <= pc+1 (wraps modulo 2^ADDR_WIDTH), budget counter +1.
REQ-019 Latency: result of an instruction visible on o_PE immediately after the edge that executes it; first instruction executes on the first edge with rst=0.
REQ-020 Opcodes: 0 NOP (hold r); 1 S_L r<=i_PE_l; 2 S_R r<=i_PE_r; 3 S_U r<=i_PE_u; 4 S_D r<=i_PE_d.
REQ-021 Opcodes: 5 MAX_L r<=max(r,i_PE_l); 6 MIN_R r<=min(r,i_PE_r); 7 MAX_U r<=max(r,i_PE_u); 8 MIN_D r<=min(r,i_PE_d); comparison unsigned over all W bits; ties keep r.
REQ-022 Opcodes: 9 RLD r<=reset value; 10 HALT sets done immediately (r held); 11 LOOP pc<=0, r held; 12-15 behave as NOP.
REQ-023 Every executed opcode, including NOP/LOOP/HALT, consumes one budget unit.
REQ-024 FIRST_IN_ROW=1: S_L and MAX_L SHALL leave r unchanged (no left neighbour); all others unaffected.
REQ-025 Neighbour inputs SHALL be sampled only at the executing edge; no combinational path from inputs to o_PE.

Reset
REQ-026 On a rising edge with rst=1: r <= {rst_memory, I[DATA_WIDTH-1:0]} (address field in MSBs), pc <= 0, budget counter <= 0, done <= 0; no instruction executes.
REQ-027 Reset mid-program SHALL abort execution and restart from pc=0 with a fresh budget; ROM contents unaffected.
REQ-028 Before the first reset edge o_PE is undefined; bench SHALL apply reset for >=1 edge.

Verification
REQ-029 ADDR=DATA=3, budget 1, ROM[0]=S_L, i_l=1,i_r=2,i_u=3,i_d=4, rst 2 edges then low -> o_PE=000001 after first edge, still 000001 four edges later.
REQ-030 Same setup, ROM[0]=S_D -> o_PE=000100 and held; ROM[0]=S_R -> 000010.
REQ-031 rst_memory=101, I=2, rst held high -> o_PE=101010; budget 0 instructions executed.
REQ-032 FIRST_IN_ROW=1, ROM[0]=S_L, rst_memory=000, I=0 -> o_PE stays 000000.
REQ-033 SORT_CYCLES=2, COMPUTE_CYCLES=2, ROM=S_U,MIN_R,MAX_L,S_D, same inputs -> o_PE 3,2,2,4 on successive edges; ROM[4] never executes, o_PE holds 4.
REQ-034 Assert rst after 2 edges of REQ-033 program -> o_PE returns to reset value next edge and program restarts at pc=0.
